// File: rtl/mem_dma_copy.sv
// mem_dma_copy -- single-channel word copier on the native mem_valid/mem_ready bus.
//
// Copies len_words 32-bit words from src_addr to dst_addr as alternating single-word
// reads and writes. Every bus request is followed by one idle bus cycle, so a responder
// that holds ready for one cycle and re-arms on valid never sees a request twice.
//
// Optional feature macro: MEM_DMA_TIMEOUT_EN
//   defined   : a watchdog aborts a request after 2**TIMEOUT_W-1 cycles without mem_ready.
//               The abort sets the sticky error flag and ends the command.
//   undefined : the engine waits indefinitely for mem_ready, and error is tied to 0.
//
// Parameters
//   LEN_W      width of len_words and the remaining-word counter
//   TIMEOUT_W  width of the watchdog counter (used only with MEM_DMA_TIMEOUT_EN)
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   start                1-cycle command strobe, sampled only while idle
//   src_addr, dst_addr   byte addresses; bits [1:0] are ignored
//   len_words            number of words to copy (0 allowed)
//   busy, done, error    status: busy outside IDLE, done pulse at command end, sticky abort flag
//   mem_valid/mem_ready  request handshake
//   mem_addr             word-aligned request address
//   mem_wdata/mem_wstrb  write data and byte strobes (strobes are 0 for reads)
//   mem_rdata            read data, valid while mem_valid and mem_ready are both high
module mem_dma_copy #(
  parameter int LEN_W     = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

  state_t           state_reg;
  logic [31:0]      src_reg;
  logic [31:0]      dst_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic [31:0]      rbuf_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             mem_valid_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;
  logic [3:0]       mem_wstrb_reg;

  // Address bits [1:0] are dropped on purpose; only word addresses are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef MEM_DMA_TIMEOUT_EN
  // The watchdog fires on the cycle that would be the (2**TIMEOUT_W-1)-th stalled cycle,
  // i.e. when the count already holds one less than the limit and ready is still low.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd_cnt_reg;
  logic                 error_reg;
  assign error = error_reg;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign error = 1'b0;
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      rbuf_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
`ifdef MEM_DMA_TIMEOUT_EN
      wd_cnt_reg    <= '0;
      error_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg       <= {src_addr[31:2], 2'b00};
            dst_reg       <= {dst_addr[31:2], 2'b00};
            remaining_reg <= len_words;
            busy_reg      <= 1'b1;
`ifdef MEM_DMA_TIMEOUT_EN
            error_reg     <= 1'b0;
            wd_cnt_reg    <= '0;
`endif
            if (len_words == '0) begin
              // Zero-length command: no bus traffic, just the done pulse.
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              mem_valid_reg <= 1'b1;
              mem_addr_reg  <= {src_addr[31:2], 2'b00};
              mem_wstrb_reg <= 4'b0000;
              state_reg     <= RD;
            end
          end
        end

        RD: begin
          if (mem_ready) begin
            rbuf_reg      <= mem_rdata;
            src_reg       <= src_reg + 32'd4;
            mem_valid_reg <= 1'b0;
            state_reg     <= RD_GAP;
          end
`ifdef MEM_DMA_TIMEOUT_EN
          else if (wd_cnt_reg == WD_LAST) begin
            mem_valid_reg <= 1'b0;
            error_reg     <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= FIN;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end

        RD_GAP: begin
          mem_valid_reg <= 1'b1;
          mem_addr_reg  <= dst_reg;
          mem_wdata_reg <= rbuf_reg;
          mem_wstrb_reg <= 4'b1111;
          state_reg     <= WR;
`ifdef MEM_DMA_TIMEOUT_EN
          wd_cnt_reg    <= '0;
`endif
        end

        WR: begin
          if (mem_ready) begin
            dst_reg       <= dst_reg + 32'd4;
            remaining_reg <= remaining_reg - 1'b1;
            mem_valid_reg <= 1'b0;
            if (remaining_reg == LEN_W'(1)) begin
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              state_reg <= WR_GAP;
            end
          end
`ifdef MEM_DMA_TIMEOUT_EN
          else if (wd_cnt_reg == WD_LAST) begin
            mem_valid_reg <= 1'b0;
            error_reg     <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= FIN;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end

        WR_GAP: begin
          mem_valid_reg <= 1'b1;
          mem_addr_reg  <= src_reg;
          mem_wstrb_reg <= 4'b0000;
          state_reg     <= RD;
`ifdef MEM_DMA_TIMEOUT_EN
          wd_cnt_reg    <= '0;
`endif
        end

        FIN: begin
          // done is high during this cycle; busy drops as we return to IDLE.
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg      <= 1'b0;
          mem_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed bench for mem_dma_copy with a 1-wait RAM responder model.
module tb_mem_dma_copy;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, error, mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_dma_copy #(.LEN_W(16), .TIMEOUT_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // ---------------- responder model ----------------
  logic [31:0] ram [0:255];
  logic        rsp_ready;
  bit          never_ready = 1'b0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_base = 0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  bit          pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] acc_addr[$];
  logic [3:0]  acc_wstrb[$];
  logic [31:0] acc_data[$];

  assign mem_ready = rsp_ready;
  assign mem_rdata = ram[mem_addr[9:2]];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rsp_ready <= 1'b0;
    else if (mem_valid && rsp_ready) rsp_ready <= 1'b0;
    else if (mem_valid && !never_ready) begin
      if (mem_addr == stall_addr && mem_wstrb == 4'h0 && (stall_cnt - stall_base) < stall_len)
        stall_cnt <= stall_cnt + 1;
      else
        rsp_ready <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'hF) ram[mem_addr[9:2]] <= mem_wdata;
      acc_addr.push_back(mem_addr);
      acc_wstrb.push_back(mem_wstrb);
      acc_data.push_back(mem_wstrb == 4'hF ? mem_wdata : mem_rdata);
      $display("[%0t] bus %s addr=%08h data=%08h wstrb=%h", $time,
               (mem_wstrb == 4'hF) ? "WRITE" : "READ ", mem_addr,
               (mem_wstrb == 4'hF) ? mem_wdata : mem_rdata, mem_wstrb);
    end
  end

  // ---------------- negedge monitors ----------------
  int          valid_cnt = 0, stall_cyc = 0, unstable = 0, gap_viol = 0, done_cnt = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [3:0]  hold_wstrb = '0;

  always @(negedge clk) begin
    if (mem_valid) begin
      valid_cnt = valid_cnt + 1;
      if (prev_hs) gap_viol = gap_viol + 1;
      if (prev_valid && !prev_hs && (mem_addr != hold_addr || mem_wstrb != hold_wstrb))
        unstable = unstable + 1;
      if (!mem_ready) stall_cyc = stall_cyc + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    hold_addr  = mem_addr;
    hold_wstrb = mem_wstrb;
    prev_valid = mem_valid;
    prev_hs    = mem_valid & mem_ready;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic ram_set(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts posedges from the start edge to the edge at which done is sampled high.
  task automatic wait_done(input int poke_at, output int cycles, output int busy_low);
    cycles = 0; busy_low = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      cycles++;
      if (cycles == poke_at) begin
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h380; len_words = 16'd9;
      end else if (cycles == poke_at + 1) begin
        start = 1'b0;
      end
      if (done) return;
      if (!busy) busy_low++;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  int cyc, blow, base, v0, d0, st0, u0, g0;

  initial begin
    // ---- reset state ----
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    // ---- T1: single word ----
    ram_set(32'h100, 32'hDEAD_BEEF);
    ram_set(32'h200, 32'h0);
    base = acc_addr.size();
    do_start(32'h100, 32'h200, 16'd1);
    wait_done(0, cyc, blow);
    check("t1_cycles", cyc, 32'd6);
    check("t1_acc_n", acc_addr.size() - base, 32'd2);
    check("t1_rd_addr", acc_addr[base], 32'h100);
    check("t1_rd_wstrb", {28'd0, acc_wstrb[base]}, 32'd0);
    check("t1_wr_addr", acc_addr[base+1], 32'h200);
    check("t1_wr_wstrb", {28'd0, acc_wstrb[base+1]}, 32'hF);
    check("t1_wr_data", acc_data[base+1], 32'hDEAD_BEEF);
    check("t1_ram", ram[128], 32'hDEAD_BEEF);
    check("t1_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // ---- T2: four contiguous words, 0x000 -> 0x040 ----
    for (int i = 0; i < 4; i++) ram_set(32'(4 * i), 32'h1111_1111 * (i + 1));
    base = acc_addr.size(); g0 = gap_viol; d0 = done_cnt;
    do_start(32'h000, 32'h040, 16'd4);
    wait_done(0, cyc, blow);
    @(negedge clk);
    check("t2_cycles", cyc, 32'd24);
    check("t2_busy_low", blow, 32'd0);
    check("t2_acc_n", acc_addr.size() - base, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rd%0d_addr", i), acc_addr[base+2*i], 32'(4 * i));
      check($sformatf("t2_wr%0d_addr", i), acc_addr[base+2*i+1], 32'h40 + 32'(4 * i));
      check($sformatf("t2_wr%0d_wstrb", i), {28'd0, acc_wstrb[base+2*i+1]}, 32'hF);
      check($sformatf("t2_ram%0d", i), ram[16+i], 32'h1111_1111 * (i + 1));
    end
    check("t2_gaps", gap_viol - g0, 32'd0);
    check("t2_done_pulses", done_cnt - d0, 32'd1);

    // ---- T3: zero length ----
    v0 = valid_cnt; base = acc_addr.size();
    do_start(32'h010, 32'h020, 16'd0);
    wait_done(0, cyc, blow);
    @(negedge clk);
    check("t3_cycles", cyc, 32'd1);
    check("t3_valid_cycles", valid_cnt - v0, 32'd0);
    check("t3_acc_n", acc_addr.size() - base, 32'd0);
    check("t3_error", {31'd0, error}, 32'd0);

    // ---- T4: 5-cycle stall on second read, start poked mid-transfer ----
    ram_set(32'h080, 32'hA0A0_0001);
    ram_set(32'h084, 32'hB0B0_0002);
    ram_set(32'h088, 32'hC0C0_0003);
    stall_addr = 32'h084; stall_base = stall_cnt; stall_len = 5;
    base = acc_addr.size(); st0 = stall_cyc; u0 = unstable; d0 = done_cnt;
    do_start(32'h080, 32'h0C0, 16'd3);
    wait_done(8, cyc, blow);
    repeat (3) @(negedge clk);
    check("t4_cycles", cyc, 32'd23);
    check("t4_stall_cycles", stall_cyc - st0, 32'd11);
    check("t4_unstable", unstable - u0, 32'd0);
    check("t4_acc_n", acc_addr.size() - base, 32'd6);
    check("t4_ram0", ram[48], 32'hA0A0_0001);
    check("t4_ram1", ram[49], 32'hB0B0_0002);
    check("t4_ram2", ram[50], 32'hC0C0_0003);
    check("t4_done_pulses", done_cnt - d0, 32'd1);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    stall_len = 0;

    // ---- T5: async reset during second write ----
    ram_set(32'h180, 32'h5555_0000);
    ram_set(32'h184, 32'h5555_0001);
    ram_set(32'h188, 32'h5555_0002);
    for (int i = 0; i < 3; i++) ram_set(32'h1C0 + 32'(4 * i), 32'h0);
    base = acc_addr.size();
    do_start(32'h180, 32'h1C0, 16'd3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_addr.size() - base == 3 && mem_valid && mem_wstrb == 4'hF) break;
    end
    check("t5_in_write", {31'd0, mem_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, mem_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_addr", mem_addr, 32'd0);
    check("t5_rst_wdata", mem_wdata, 32'd0);
    check("t5_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk);
    check("t5_word1_abandoned", ram[113], 32'd0);
    rstn = 1'b1;
    base = acc_addr.size();
    do_start(32'h180, 32'h1C0, 16'd3);
    wait_done(0, cyc, blow);
    @(negedge clk);
    check("t5_cycles", cyc, 32'd18);
    check("t5_first_addr", acc_addr[base], 32'h180);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_ram%0d", i), ram[112+i], 32'h5555_0000 + 32'(i));

`ifdef MEM_DMA_TIMEOUT_EN
    // ---- T6: responder never ready -> watchdog abort ----
    never_ready = 1'b1;
    v0 = valid_cnt; d0 = done_cnt; base = acc_addr.size();
    do_start(32'h000, 32'h100, 16'd2);
    wait_done(0, cyc, blow);
    check("t6_cycles", cyc, 32'd16);
    check("t6_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check("t6_valid_cycles", valid_cnt - v0, 32'd15);
    check("t6_done_pulses", done_cnt - d0, 32'd1);
    check("t6_acc_n", acc_addr.size() - base, 32'd0);
    check("t6_error_sticky", {31'd0, error}, 32'd1);
    never_ready = 1'b0;
    do_start(32'h000, 32'h100, 16'd1);
    check("t6_error_cleared", {31'd0, error}, 32'd0);
    wait_done(0, cyc, blow);
    check("t6_recover_cycles", cyc, 32'd6);
`else
    check("error_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
